// File: rtl/mem_read_arbiter_rr_pkg.sv
// Shared types and the cyclic round-robin pick for the memory read arbiter.
// Also supplies default bus widths when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

    localparam int MAX_READ_MASTERS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Returns the first requester strictly after ptr, wrapping at n; ptr itself is checked last.
    function automatic logic [3:0] rr_pick(input logic [MAX_READ_MASTERS-1:0] req,
                                           input logic [3:0] ptr,
                                           input int n);
        logic [3:0] pick;
        int         idx;
        pick = '0;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (req[idx]) pick = 4'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_rr_arbiter.sv
// Combinational cyclic-priority pick over N requesters, starting after i_ptr.
// Kept generic so a write-side arbiter can reuse it unchanged.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [MAX_READ_MASTERS-1:0] w_req_ext;
    logic [3:0]                  w_pick;

    always_comb begin
        w_req_ext         = '0;
        w_req_ext[N-1:0]  = i_req;
        w_pick            = rr_pick(w_req_ext, 4'(i_ptr), N);
        o_idx             = IW'(w_pick);
        o_any             = |i_req;
    end

endmodule

// File: rtl/mem_read_arbiter_rr.sv
// N-master AXI read arbiter: one burst at a time, round-robin, ARID tagged with master index.
// Optional statistics counters are enabled with the macro MEM_RD_ARB_STATS_EN.
module mem_read_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int READ_MASTERS = 3,
    parameter int ID_WIDTH     = 4,
    parameter int LEN_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [READ_MASTERS-1:0]              m_arvalid,
    input  logic [READ_MASTERS*`ADDR_WIDTH-1:0]  m_araddr,
    input  logic [READ_MASTERS*LEN_WIDTH-1:0]    m_arlen,
    output logic [READ_MASTERS-1:0]              m_arready,
    output logic [READ_MASTERS-1:0]              m_rvalid,
    output logic [READ_MASTERS-1:0]              m_rlast,
    output logic [`DATA_WIDTH-1:0]               m_rdata,
    input  logic [READ_MASTERS-1:0]              m_rready,
    output logic                                 ARVALID,
    output logic [ID_WIDTH-1:0]                  ARID,
    output logic [LEN_WIDTH-1:0]                 ARLEN,
    output logic [`ADDR_WIDTH-1:0]               ARADDR,
    input  logic                                 ARREADY,
    input  logic                                 RVALID,
    input  logic                                 RLAST,
    input  logic [ID_WIDTH-1:0]                  RID,
    input  logic [`DATA_WIDTH-1:0]               RDATA,
    output logic                                 RREADY,
    output logic                                 err_len
`ifdef MEM_RD_ARB_STATS_EN
    ,
    output logic [READ_MASTERS*32-1:0]           stat_grants,
    output logic [READ_MASTERS*32-1:0]           stat_wait
`endif
);

    localparam int IW = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1;

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic [IW-1:0]        r_grant;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        w_pick;
    logic                 w_any;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH:0]   r_beat;
    logic                 r_err;
    logic                 w_arvalid;
    logic                 w_ar_hs;
    logic                 w_rready;
    logic                 w_r_beat;

    rr_arbiter #(
        .N  (READ_MASTERS),
        .IW (IW)
    ) u_rr (
        .i_req (m_arvalid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ARVALID   = 1'b0;
        ARID      = '0;
        ARLEN     = '0;
        ARADDR    = '0;
        RREADY    = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        w_arvalid = 1'b0;
        w_ar_hs   = 1'b0;
        w_rready  = 1'b0;
        w_r_beat  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) w_next = ADDR;
            end
            ADDR: begin
                w_arvalid          = m_arvalid[r_grant];
                ARVALID            = w_arvalid;
                ARID               = ID_WIDTH'(r_grant);
                ARLEN              = m_arlen[int'(r_grant)*LEN_WIDTH +: LEN_WIDTH];
                ARADDR             = m_araddr[int'(r_grant)*`ADDR_WIDTH +: `ADDR_WIDTH];
                m_arready[r_grant] = ARREADY;
                w_ar_hs            = w_arvalid && ARREADY;
                // A master withdrawing its request abandons the grant without moving the pointer.
                if (w_ar_hs)         w_next = DATA;
                else if (!w_arvalid) w_next = IDLE;
            end
            DATA: begin
                w_rready          = m_rready[r_grant];
                RREADY            = w_rready;
                m_rvalid[r_grant] = RVALID;
                m_rlast[r_grant]  = RLAST;
                w_r_beat          = RVALID && w_rready;
                if (w_r_beat && RLAST) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_ptr   <= IW'(READ_MASTERS - 1);
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
                r_len   <= m_arlen[int'(w_pick)*LEN_WIDTH +: LEN_WIDTH];
            end
            if (w_ar_hs) r_beat <= '0;
            if (w_r_beat) begin
                r_beat <= r_beat + 1'b1;
                if (RLAST) r_ptr <= r_grant;
                if ((RLAST && (r_beat != {1'b0, r_len})) || (RID != ID_WIDTH'(r_grant)))
                    r_err <= 1'b1;
            end
        end
    end

    assign m_rdata = RDATA;
    assign err_len = r_err;

`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0] r_stat_grants [READ_MASTERS];
    logic [31:0] r_stat_wait   [READ_MASTERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_MASTERS; i++) begin
                r_stat_grants[i] <= '0;
                r_stat_wait[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < READ_MASTERS; i++) begin
                if (w_r_beat && RLAST && (r_grant == IW'(i)) && (r_stat_grants[i] != '1))
                    r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
                // Waiting means requesting while some other master (or nobody yet) holds the grant.
                if (m_arvalid[i] && !((r_state != IDLE) && (r_grant == IW'(i))) &&
                    (r_stat_wait[i] != '1))
                    r_stat_wait[i] <= r_stat_wait[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        stat_wait   = '0;
        for (int i = 0; i < READ_MASTERS; i++) begin
            stat_grants[i*32 +: 32] = r_stat_grants[i];
            stat_wait[i*32 +: 32]   = r_stat_wait[i];
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_arbiter_rr.sv
// Bench for mem_read_arbiter_rr: vector table, directed corner sequences, randomized traffic.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_read_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_arvalid;
    logic [95:0] m_araddr;
    logic [11:0] m_arlen;
    logic [2:0]  m_arready;
    logic [2:0]  m_rvalid;
    logic [2:0]  m_rlast;
    logic [31:0] m_rdata;
    logic [2:0]  m_rready;
    logic        ARVALID;
    logic [3:0]  ARID;
    logic [3:0]  ARLEN;
    logic [31:0] ARADDR;
    logic        ARREADY;
    logic        RVALID;
    logic        RLAST;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic        RREADY;
    logic        err_len;
`ifdef MEM_RD_ARB_STATS_EN
    logic [95:0] stat_grants;
    logic [95:0] stat_wait;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_read_arbiter_rr #(
        .READ_MASTERS (3),
        .ID_WIDTH     (4),
        .LEN_WIDTH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rdata   (m_rdata),
        .m_rready  (m_rready),
        .ARVALID   (ARVALID),
        .ARID      (ARID),
        .ARLEN     (ARLEN),
        .ARADDR    (ARADDR),
        .ARREADY   (ARREADY),
        .RVALID    (RVALID),
        .RLAST     (RLAST),
        .RID       (RID),
        .RDATA     (RDATA),
        .RREADY    (RREADY),
        .err_len   (err_len)
`ifdef MEM_RD_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_wait   (stat_wait)
`endif
    );

    typedef struct {
        logic [2:0]  arv;
        logic        ardy;
        logic        rv;
        logic        rl;
        logic [3:0]  rid;
        logic [2:0]  rrdy;
        logic        e_arv;
        logic [3:0]  e_arid;
        logic [31:0] e_addr;
        logic [2:0]  e_arrdy;
        logic [2:0]  e_rv;
        logic [2:0]  e_rl;
        logic        e_rrdy;
        logic        e_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_arvalid = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RID       = '0;
        RDATA     = '0;
        m_rready  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_arv(input string nm);
        int n = 0;
        while (!ARVALID && n < 10) begin
            step();
            n++;
        end
        if (!ARVALID) chk({nm, " arvalid timeout"}, 64'(ARVALID), 64'(1));
    endtask

    // Round-robin rule: first requester strictly after the last granted master, wrapping.
    function automatic int model_pick(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++)
            if (req[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    initial begin
        int phase, gid, last, cur_len, cur_beat, drop;

        vecs[0]  = '{3'b010,1'b0,1'b0,1'b0,4'd0,3'b000, 1'b0,4'd0,32'h0,  3'b000,3'b000,3'b000,1'b0,1'b0};
        vecs[1]  = '{3'b010,1'b1,1'b0,1'b0,4'd0,3'b000, 1'b1,4'd1,32'h100,3'b010,3'b000,3'b000,1'b0,1'b0};
        vecs[2]  = '{3'b000,1'b0,1'b1,1'b0,4'd1,3'b010, 1'b0,4'd0,32'h0,  3'b000,3'b010,3'b000,1'b1,1'b0};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = '{3'b000,1'b0,1'b1,1'b1,4'd1,3'b010, 1'b0,4'd0,32'h0,  3'b000,3'b010,3'b010,1'b1,1'b0};
        vecs[6]  = '{3'b000,1'b0,1'b0,1'b0,4'd0,3'b000, 1'b0,4'd0,32'h0,  3'b000,3'b000,3'b000,1'b0,1'b0};
        vecs[7]  = '{3'b001,1'b0,1'b0,1'b0,4'd0,3'b000, 1'b0,4'd0,32'h0,  3'b000,3'b000,3'b000,1'b0,1'b0};
        vecs[8]  = '{3'b001,1'b1,1'b0,1'b0,4'd0,3'b000, 1'b1,4'd0,32'h0,  3'b001,3'b000,3'b000,1'b0,1'b0};
        vecs[9]  = '{3'b000,1'b0,1'b1,1'b0,4'd0,3'b001, 1'b0,4'd0,32'h0,  3'b000,3'b001,3'b000,1'b1,1'b0};
        vecs[10] = '{3'b000,1'b0,1'b1,1'b1,4'd0,3'b001, 1'b0,4'd0,32'h0,  3'b000,3'b001,3'b001,1'b1,1'b0};
        vecs[11] = '{3'b000,1'b0,1'b0,1'b0,4'd0,3'b000, 1'b0,4'd0,32'h0,  3'b000,3'b000,3'b000,1'b0,1'b1};
        vecs[12] = vecs[11];

        for (int i = 0; i < 3; i++) m_araddr[i*32 +: 32] = 32'(i * 256);
        m_arlen = 12'h333;
        rst_n   = 1'b0;
        idle_inputs();
        step();
        step();
        chk("reset arvalid", 64'(ARVALID), 64'(0));
        chk("reset m_arready", 64'(m_arready), 64'(0));
        chk("reset m_rvalid", 64'(m_rvalid), 64'(0));
        chk("reset rready", 64'(RREADY), 64'(0));
        chk("reset err_len", 64'(err_len), 64'(0));
        rst_n = 1'b1;

        // Basic 4-beat burst for master 1, then a short-RLAST burst for master 0.
        for (int r = 0; r < 13; r++) begin
            m_arvalid = vecs[r].arv;
            ARREADY   = vecs[r].ardy;
            RVALID    = vecs[r].rv;
            RLAST     = vecs[r].rl;
            RID       = vecs[r].rid;
            m_rready  = vecs[r].rrdy;
            #1;
            chk($sformatf("v%0d arvalid", r), 64'(ARVALID), 64'(vecs[r].e_arv));
            chk($sformatf("v%0d m_arready", r), 64'(m_arready), 64'(vecs[r].e_arrdy));
            chk($sformatf("v%0d m_rvalid", r), 64'(m_rvalid), 64'(vecs[r].e_rv));
            chk($sformatf("v%0d m_rlast", r), 64'(m_rlast), 64'(vecs[r].e_rl));
            chk($sformatf("v%0d rready", r), 64'(RREADY), 64'(vecs[r].e_rrdy));
            chk($sformatf("v%0d err_len", r), 64'(err_len), 64'(vecs[r].e_err));
            if (vecs[r].e_arv) begin
                chk($sformatf("v%0d arid", r), 64'(ARID), 64'(vecs[r].e_arid));
                chk($sformatf("v%0d araddr", r), 64'(ARADDR), 64'(vecs[r].e_addr));
            end
            step();
        end

        do_reset();
        chk("err cleared by reset", 64'(err_len), 64'(0));

        // Three masters requesting continuously with single-beat bursts.
        m_arlen   = 12'h000;
        m_arvalid = 3'b111;
        m_rready  = 3'b111;
        for (int b = 0; b < 6; b++) begin
            wait_arv($sformatf("order%0d", b));
            chk($sformatf("order%0d arid", b), 64'(ARID), 64'(b % 3));
            ARREADY = 1'b1;
            step();
            ARREADY = 1'b0;
            RVALID  = 1'b1;
            RLAST   = 1'b1;
            RID     = 4'(b % 3);
            step();
            RVALID  = 1'b0;
            RLAST   = 1'b0;
        end
        chk("order err_len", 64'(err_len), 64'(0));

        // Master 0 requests while master 2 owns the bus.
        do_reset();
        m_rready      = 3'b111;
        m_arlen[11:8] = 4'd1;
        m_arlen[3:0]  = 4'd0;
        m_arvalid     = 3'b100;
        step();
        ARREADY = 1'b1;
        #1;
        chk("mid arid m2", 64'(ARID), 64'(2));
        step();
        ARREADY   = 1'b0;
        m_arvalid = 3'b001;
        RVALID    = 1'b1;
        RID       = 4'd2;
        RLAST     = 1'b0;
        #1;
        chk("mid m_arready during data", 64'(m_arready), 64'(0));
        chk("mid arvalid during data", 64'(ARVALID), 64'(0));
        chk("mid m_rvalid", 64'(m_rvalid), 64'(3'b100));
        step();
        RLAST = 1'b1;
        #1;
        chk("mid m_rlast", 64'(m_rlast), 64'(3'b100));
        step();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        #1;
        chk("mid idle gap arvalid", 64'(ARVALID), 64'(0));
        step();
        #1;
        chk("mid m0 arvalid", 64'(ARVALID), 64'(1));
        chk("mid m0 arid", 64'(ARID), 64'(0));
        ARREADY = 1'b1;
        step();
        ARREADY   = 1'b0;
        m_arvalid = 3'b000;
        RVALID    = 1'b1;
        RLAST     = 1'b1;
        RID       = 4'd0;
        step();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        chk("mid err_len", 64'(err_len), 64'(0));

        // Downstream stalls the address for five cycles.
        m_arlen[11:8] = 4'd0;
        m_arvalid     = 3'b100;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d arvalid", k), 64'(ARVALID), 64'(1));
            chk($sformatf("stall%0d araddr", k), 64'(ARADDR), 64'(32'h200));
            chk($sformatf("stall%0d m_arready", k), 64'(m_arready), 64'(0));
            step();
        end
        ARREADY = 1'b1;
        #1;
        chk("stall m_arready pulse", 64'(m_arready), 64'(3'b100));
        step();
        ARREADY   = 1'b0;
        m_arvalid = 3'b000;
        RVALID    = 1'b1;
        RLAST     = 1'b1;
        RID       = 4'd2;
        #1;
        chk("stall m_rvalid", 64'(m_rvalid), 64'(3'b100));
        step();
        RVALID = 1'b0;
        RLAST  = 1'b0;
        chk("stall err_len", 64'(err_len), 64'(0));

        // Reset lands in the middle of a data phase.
        m_arlen[3:0] = 4'd3;
        m_arvalid    = 3'b001;
        step();
        ARREADY = 1'b1;
        step();
        ARREADY   = 1'b0;
        m_arvalid = 3'b000;
        RVALID    = 1'b1;
        RID       = 4'd0;
        m_rready  = 3'b001;
        #1;
        chk("rstmid m_rvalid before", 64'(m_rvalid), 64'(3'b001));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid arvalid", 64'(ARVALID), 64'(0));
        chk("rstmid m_rvalid", 64'(m_rvalid), 64'(0));
        chk("rstmid m_arready", 64'(m_arready), 64'(0));
        chk("rstmid rready", 64'(RREADY), 64'(0));
        chk("rstmid m_rlast", 64'(m_rlast), 64'(0));
        idle_inputs();
        step();
        rst_n     = 1'b1;
        m_arvalid = 3'b110;
        step();
        #1;
        chk("rstmid regrant arvalid", 64'(ARVALID), 64'(1));
        chk("rstmid regrant arid", 64'(ARID), 64'(1));

        // Randomized traffic against a transaction-level model.
        do_reset();
        phase = 0;
        gid   = 0;
        last  = 2;
        cur_len  = 0;
        cur_beat = 0;
        drop     = -1;
        for (int c = 0; c < 3000; c++) begin
            if (drop >= 0) begin
                m_arvalid[drop] = 1'b0;
                drop = -1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!m_arvalid[i] && $urandom_range(0, 3) == 0) begin
                    m_arvalid[i]         = 1'b1;
                    m_araddr[i*32 +: 32] = $urandom;
                    m_arlen[i*4 +: 4]    = 4'($urandom_range(0, 3));
                end
            end
            ARREADY  = 1'($urandom_range(0, 1));
            m_rready = 3'($urandom);
            RDATA    = $urandom;
            RID      = 4'(gid);
            if (phase == 2) begin
                RVALID = 1'($urandom_range(0, 1));
                RLAST  = RVALID && (cur_beat == cur_len);
            end else begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
            end
            #1;
            chk("rnd m_rdata", 64'(m_rdata), 64'(RDATA));
            case (phase)
                0: begin
                    chk("rnd idle arvalid", 64'(ARVALID), 64'(0));
                    chk("rnd idle rready", 64'(RREADY), 64'(0));
                    if (m_arvalid != 3'b000) begin
                        gid   = model_pick(m_arvalid, last);
                        phase = 1;
                    end
                end
                1: begin
                    chk("rnd addr arvalid", 64'(ARVALID), 64'(1));
                    chk("rnd addr arid", 64'(ARID), 64'(gid));
                    chk("rnd addr araddr", 64'(ARADDR), 64'(m_araddr[gid*32 +: 32]));
                    chk("rnd addr arlen", 64'(ARLEN), 64'(m_arlen[gid*4 +: 4]));
                    chk("rnd addr m_arready", 64'(m_arready), 64'(ARREADY ? 3'(1 << gid) : 3'b000));
                    if (ARREADY) begin
                        phase    = 2;
                        cur_len  = int'(m_arlen[gid*4 +: 4]);
                        cur_beat = 0;
                        drop     = gid;
                    end
                end
                default: begin
                    chk("rnd data m_rvalid", 64'(m_rvalid), 64'(RVALID ? 3'(1 << gid) : 3'b000));
                    chk("rnd data m_rlast", 64'(m_rlast), 64'(RLAST ? 3'(1 << gid) : 3'b000));
                    chk("rnd data rready", 64'(RREADY), 64'(m_rready[gid]));
                    chk("rnd data m_arready", 64'(m_arready), 64'(0));
                    if (RVALID && m_rready[gid]) begin
                        if (RLAST) begin
                            phase = 0;
                            last  = gid;
                        end else begin
                            cur_beat++;
                        end
                    end
                end
            endcase
            step();
        end
        chk("rnd err_len", 64'(err_len), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter_rr.md
Name: mem_read_arbiter_rr

Overview:
- Parametrised N-master AXI read arbiter for the core's memory subsystem.
- Masters: i-cache, d-cache, stream buffer(s) and any future prefetchers.
- Grants one burst at a time in round-robin order and forwards the AR channel to the single downstream read port.
- Routes R beats back to the granted master and tags ARID with the master index; checks burst length.

Parameters:
- READ_MASTERS, 3, number of read masters (1..16).
- ID_WIDTH, 4, width of ARID/RID.
- LEN_WIDTH, 4, width of ARLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m_arvalid  in  READ_MASTERS  per-master address valid
- m_araddr  in  READ_MASTERS*`ADDR_WIDTH  per-master address, packed, master 0 in LSBs
- m_arlen  in  READ_MASTERS*LEN_WIDTH  per-master burst length minus 1
- m_arready  out  READ_MASTERS  per-master address accepted
- m_rvalid  out  READ_MASTERS  per-master data valid
- m_rlast  out  READ_MASTERS  per-master last beat
- m_rdata  out  `DATA_WIDTH  read data, broadcast to all masters
- m_rready  in  READ_MASTERS  per-master data ready
- ARVALID  out  1  downstream address valid
- ARID  out  ID_WIDTH  granted master index
- ARLEN  out  LEN_WIDTH  granted master's ARLEN
- ARADDR  out  `ADDR_WIDTH  granted master's address
- ARREADY  in  1  downstream address ready
- RVALID  in  1  downstream data valid
- RLAST  in  1  downstream last beat
- RID  in  ID_WIDTH  downstream data ID
- RDATA  in  `DATA_WIDTH  downstream data
- RREADY  out  1  downstream data ready
- err_len  out  1  sticky: RLAST on the wrong beat, or RID not equal to the grant

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, rr_ptr=READ_MASTERS-1 (master 0 wins first), beat_cnt=0, err_len=0.
  - All valid/ready outputs 0.
  - Reset mid-burst abandons the burst immediately.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, register grant = first requester strictly after rr_ptr, cyclic.
  - Go to ADDR and latch ARLEN into len_q.
  - Request-to-ARVALID latency is 1 cycle.
- ADDR:
  - ARVALID=m_arvalid[grant]; ARADDR and ARLEN are muxed from the grant; ARID=grant zero-extended.
  - m_arready[grant]=ARREADY; all other m_arready are 0.
  - On ARVALID&&ARREADY go to DATA with beat_cnt=0.
  - If the master drops m_arvalid before the handshake (protocol violation), return to IDLE without updating rr_ptr.
- DATA:
  - m_rvalid[grant]=RVALID, m_rlast[grant]=RLAST, RREADY=m_rready[grant]; all other m_rvalid/m_rlast are 0.
  - Each RVALID&&RREADY beat increments beat_cnt (width LEN_WIDTH+1, no wrap for legal lengths).
  - On a beat with RLAST: go to IDLE and set rr_ptr=grant.
  - err_len is set when RLAST arrives with beat_cnt!=len_q, or when RID!=grant on a beat.
- One outstanding burst only. A new arbitration occurs the cycle after the last beat, so the IDLE gap costs 1 cycle.
- The last-granted master has lowest priority next round. A master requesting continuously alone is re-granted every burst.
- RVALID arriving in IDLE or ADDR is ignored (RREADY=0 there).
- m_rdata=RDATA always.

Optional Feature:
- Macro: MEM_RD_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (READ_MASTERS*32): per-master saturating count of completed bursts.
  - Adds output stat_wait (READ_MASTERS*32): per-master saturating count of cycles with m_arvalid high but not granted.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_t {IDLE, ADDR, DATA}.
  - Function rr_pick(req, ptr) returning the next index.
  - localparam MAX_READ_MASTERS=16.
- Sub-module rr_arbiter: combinational cyclic priority pick, parametrised by N, reusable for a future write arbiter.
- FSM, muxes and counters stay in the top module.

Test Plan:
- Reset release, master 1 requests addr 0x100 len 3:
  - ARVALID at the 2nd cycle with ARID=1, ARADDR=0x100.
  - 4 beats reach m_rvalid[1] only; the last carries m_rlast[1]; err_len=0.
- Masters 0, 1, 2 request continuously, len 0 each: grant order 0,1,2,0,1,2 across 6 bursts.
- Master 2 is granted while master 0 requests mid-burst:
  - Master 0 is granted only after master 2's RLAST.
  - Grant takes effect on the cycle after RLAST, ARVALID on the next.
- ARREADY held 0 for 5 cycles: ARVALID/ARADDR stay stable, m_arready stays 0, then completes on the ARREADY pulse.
- Downstream sends RLAST on beat 2 of an ARLEN=3 burst: err_len=1 and stays 1 until rst_n; FSM returns to IDLE.
- rst_n asserted mid-DATA:
  - All outputs are 0 asynchronously.
  - After release, the first requester granted is the lowest index among requesters.
